// File: rtl/rs232_pkg.sv
// Shared definitions for the rs232 send/receive family: byte type, baud timing
// and the default transmit FIFO depth.
package rs232_pkg;

  typedef logic [7:0] byte_t;

  localparam int RS232_CLK_HZ    = 12_000_000;
  localparam int RS232_BAUD      = 9600;
  // Clock cycles per bit on the line (1250 at 12 MHz / 9600 baud).
  localparam int RS232_BAUD_PERIOD = RS232_CLK_HZ / RS232_BAUD;

  localparam int RS232_TX_FIFO_DEPTH_LOG2 = 4;

endpackage

// File: rtl/rs232_edge_detect.sv
// One-register rising-edge detector; rise is high in the cycle where in is
// high and was low on the previous clock.
module rs232_edge_detect (
  input  logic clk,
  input  logic resetn,
  input  logic in,
  output logic rise
);

  logic in_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its inputs regardless of block evaluation order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) in_q <= 1'b0;
    else         in_q <= in;
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/rs232_tx_fifo.sv
// Byte FIFO feeding rs232_send: single-cycle writes in, head byte out with en,
// popped on each data_clk rising edge. Optional RS232_TX_FIFO_OVERFLOW_EN adds
// a sticky overflow flag with a clear input.
module rs232_tx_fifo
  import rs232_pkg::*;
#(
  parameter int DEPTH_LOG2 = RS232_TX_FIFO_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  resetn,
`ifdef RS232_TX_FIFO_OVERFLOW_EN
  input  logic                  overflow_clr,
  output logic                  overflow,
`endif
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic [7:0]            data_byte,
  output logic                  en,
  input  logic                  data_clk
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] ONE_COUNT  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] ONE_PTR  = DEPTH_LOG2'(1);

  byte_t                 mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  dclk_rise;
  logic                  push;
  logic                  pop;

  rs232_edge_detect u_dclk_edge (
    .clk    (clk),
    .resetn (resetn),
    .in     (data_clk),
    .rise   (dclk_rise)
  );

  // Flags come from the registered count only, so a write in the same cycle
  // as a pop from a full FIFO is still dropped.
  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);
  assign level = count;
  assign en    = ~empty;

  assign push = wr_en & ~full;
  assign pop  = dclk_rise & ~empty;

  // NOTE: the storage array is reset on purpose so data_byte is deterministic
  // after reset; a RAM macro could not do this, a register array can.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE_PTR;
      if (pop)  rd_ptr <= rd_ptr + ONE_PTR;
      unique case ({push, pop})
        2'b10:   count <= count + ONE_COUNT;
        2'b01:   count <= count - ONE_COUNT;
        default: count <= count;
      endcase
    end
  end

  // Head byte straight from storage; no bypass path from wr_data.
  assign data_byte = empty ? 8'h00 : mem[rd_ptr];

`ifdef RS232_TX_FIFO_OVERFLOW_EN
  // Set has priority over clear so an overflow in the clear cycle is kept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)             overflow <= 1'b0;
    else if (wr_en && full)  overflow <= 1'b1;
    else if (overflow_clr)   overflow <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_rs232_tx_fifo.sv
// Scoreboard bench for rs232_tx_fifo: queue-based reference model, negedge
// monitor, directed scenarios plus a randomized traffic phase.
module tb_rs232_tx_fifo;
  import rs232_pkg::*;

  localparam int DL2   = 4;
  localparam int DEPTH = 1 << DL2;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic [7:0]     wr_data = '0;
  logic           wr_en = 1'b0;
  logic           full, empty, en;
  logic [DL2:0]   level;
  logic [7:0]     data_byte;
  logic           data_clk = 1'b0;
`ifdef RS232_TX_FIFO_OVERFLOW_EN
  logic           overflow_clr = 1'b0;
  logic           overflow;
  logic           m_ovf = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  byte_t exp_q[$];   // reference FIFO contents
  byte_t tx_log[$];  // bytes captured by the modelled sender
  byte_t want[$];
  logic  m_dc_prev = 1'b0;
  logic  mon_dc_prev = 1'b0;

  always #5 clk = ~clk;

  rs232_tx_fifo #(.DEPTH_LOG2(DL2)) dut (
    .clk       (clk),
    .resetn    (resetn),
`ifdef RS232_TX_FIFO_OVERFLOW_EN
    .overflow_clr (overflow_clr),
    .overflow     (overflow),
`endif
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .data_byte (data_byte),
    .en        (en),
    .data_clk  (data_clk)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of bytes with the accept/pop rules applied to
  // the occupancy seen before each clock edge.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exp_q.delete();
      m_dc_prev = 1'b0;
`ifdef RS232_TX_FIFO_OVERFLOW_EN
      m_ovf = 1'b0;
`endif
    end else begin
      automatic int sz = exp_q.size();
      if (data_clk && !m_dc_prev && sz > 0) void'(exp_q.pop_front());
      if (wr_en && sz < DEPTH) exp_q.push_back(wr_data);
`ifdef RS232_TX_FIFO_OVERFLOW_EN
      if (wr_en && sz == DEPTH) m_ovf = 1'b1;
      else if (overflow_clr)    m_ovf = 1'b0;
`endif
      m_dc_prev = data_clk;
    end
  end

  // Monitor: compares every output against the model once per cycle and
  // logs the byte the sender captures on each data_clk rise.
  always @(negedge clk) begin
    if (!resetn) begin
      mon_dc_prev = 1'b0;
    end else begin
      automatic int sz = exp_q.size();
      check("level", 32'(level), 32'(sz));
      check("empty", 32'(empty), 32'(sz == 0));
      check("full",  32'(full),  32'(sz == DEPTH));
      check("en",    32'(en),    32'(sz != 0));
      check("data_byte", 32'(data_byte), (sz != 0) ? 32'(exp_q[0]) : 32'h0);
`ifdef RS232_TX_FIFO_OVERFLOW_EN
      check("overflow", 32'(overflow), 32'(m_ovf));
`endif
      if (data_clk && !mon_dc_prev && en) tx_log.push_back(data_byte);
      mon_dc_prev = data_clk;
    end
  end

  // Drive one cycle of inputs just after an edge; returns 1 ns after the next edge.
  task automatic cycle(input logic we, input logic [7:0] wd, input logic dc);
    wr_en = we; wr_data = wd; data_clk = dc;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && en; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b1);  // held high: must not pop twice
      cycle(1'b0, 8'h00, 1'b0);
    end
    check("drain_done_en", 32'(en), 32'h0);
  endtask

  task automatic compare_log(input string name, input int base);
    check({name, "_len"}, 32'(tx_log.size() - base), 32'(want.size()));
    for (int i = 0; i < want.size() && base + i < tx_log.size(); i++)
      check({name, "_byte"}, 32'(tx_log[base + i]), 32'(want[i]));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_empty"}, 32'(empty), 32'h1);
    check({name, "_full"},  32'(full),  32'h0);
    check({name, "_level"}, 32'(level), 32'h0);
    check({name, "_en"},    32'(en),    32'h0);
    check({name, "_data"},  32'(data_byte), 32'h0);
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int gap, hi, pct;
    logic dc;

    #23; check_reset_outputs("in_reset");
    @(posedge clk); #1; resetn = 1'b1;

    // Idle, then a data_clk pulse while empty must change nothing.
    for (int i = 0; i < 100; i++) cycle(1'b0, 8'h00, 1'b0);
    check_reset_outputs("idle");
    cycle(1'b0, 8'h00, 1'b1); cycle(1'b0, 8'h00, 1'b0);
    check_reset_outputs("pulse_empty");
    base = tx_log.size();
    cycle(1'b1, 8'h12, 1'b0);
    check("no_ptr_move_data", 32'(data_byte), 32'h12);
    drain();
    want = '{8'h12}; compare_log("empty_pulse", base);

    // Three-byte burst, level walks 3,2,1,0.
    base = tx_log.size();
    cycle(1'b1, 8'hFF, 1'b0);
    check("en_after_first_write", 32'(en), 32'h1);
    cycle(1'b1, 8'hAA, 1'b0);
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    check("burst_level3", 32'(level), 32'd3);
    for (int i = 2; i >= 0; i--) begin
      cycle(1'b0, 8'h00, 1'b1);
      check("burst_level", 32'(level), 32'(i));
      for (int g = 0; g < 5; g++) cycle(1'b0, 8'h00, 1'b0);
    end
    check("burst_en_low", 32'(en), 32'h0);
    want = '{8'hFF, 8'hAA, 8'hA5}; compare_log("burst", base);

    // Fill to full, then a dropped 17th write.
    base = tx_log.size();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0);
    cycle(1'b1, 8'h10, 1'b0);
    check("full_flag", 32'(full), 32'h1);
    check("full_level", 32'(level), 32'(DEPTH));
`ifdef RS232_TX_FIFO_OVERFLOW_EN
    check("overflow_set", 32'(overflow), 32'h1);
    overflow_clr = 1'b1; cycle(1'b0, 8'h00, 1'b0); overflow_clr = 1'b0;
    check("overflow_clr", 32'(overflow), 32'h0);
`endif
    drain();
    want.delete();
    for (int i = 0; i < DEPTH; i++) want.push_back(8'(i));
    compare_log("overfill", base);

    // Simultaneous push and pop with a single entry.
    base = tx_log.size();
    cycle(1'b1, 8'h31, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h32, 1'b1);
    check("pp_level", 32'(level), 32'h1);
    check("pp_data", 32'(data_byte), 32'h32);
    check("pp_en", 32'(en), 32'h1);
    cycle(1'b0, 8'h00, 1'b0);
    drain();
    want = '{8'h31, 8'h32}; compare_log("push_pop", base);

    // Pointer wrap: 10 in, 4 out, 10 more in (full), drain.
    base = tx_log.size();
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 8'h00, 1'b1); cycle(1'b0, 8'h00, 1'b0);
    end
    for (int i = 10; i < 20; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
    check("wrap_full", 32'(full), 32'h1);
    drain();
    want.delete();
    for (int i = 0; i < 20; i++) want.push_back(8'(8'h40 + i));
    compare_log("wrap", base);

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    check("pre_reset_level", 32'(level), 32'd5);
    #3 resetn = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(posedge clk); #1; resetn = 1'b1;
    base = tx_log.size();
    cycle(1'b1, 8'h55, 1'b0);
    drain();
    want = '{8'h55}; compare_log("after_reset", base);

    // Randomized traffic: heavy writes then light writes, random sender pacing.
    gap = 0; hi = 0;
    for (int i = 0; i < 4000; i++) begin
      pct = (i < 2000) ? 70 : 15;
      if (hi > 0) begin dc = 1'b1; hi--; end
      else if (gap > 0) begin dc = 1'b0; gap--; end
      else if (en) begin dc = 1'b1; hi = $urandom_range(0, 2); gap = $urandom_range(1, 10); end
      else dc = 1'b0;
      cycle(($urandom_range(0, 99) < pct), 8'($urandom), dc);
    end
    cycle(1'b0, 8'h00, 1'b0);
    drain();
    check("final_model_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
